// File: rtl/layer_2_mac.sv
// Output layer: ten saturating fixed-point MAC lanes fed by a stream of hidden activations.
// Weights come from an external one-cycle-latency memory addressed by hidden index.
module layer_2_mac #(
  parameter int unsigned BITS   = 32,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned HIDDEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hid_valid,
  input  logic [BITS-1:0]      hid_data,
  output logic                 hid_ready,
  output logic                 w_rd_en,
  output logic [7:0]           w_addr,
  input  logic [BITS*10-1:0]   w_data,
  input  logic [BITS*10-1:0]   bias,
  output logic [BITS*10-1:0]   layer_2,
  output logic                 out_valid,
  input  logic                 out_ack
);

  localparam int unsigned N_OUT = 10;
  localparam int unsigned PW    = 2 * BITS;
  localparam logic signed [BITS-1:0] SMAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] SMIN = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              count_q, count_d;
  logic signed [BITS-1:0]  h_q, h_d;
  logic                    mac_q, mac_d;
  logic signed [BITS-1:0]  acc_q [N_OUT];
  logic signed [BITS-1:0]  acc_d [N_OUT];
  logic [BITS*N_OUT-1:0]   layer_2_q, layer_2_d;
  logic                    out_valid_q, out_valid_d;
  logic                    hs;

  // Full-width product, floor shift, clamp to the word range.
  function automatic logic signed [BITS-1:0] mul_shift_sat(input logic signed [BITS-1:0] h,
                                                           input logic signed [BITS-1:0] w);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sh;
    prod = PW'(h) * PW'(w);
    sh   = prod >>> FRAC;
    if (sh[PW-1:BITS-1] == {(BITS+1){sh[PW-1]}}) return sh[BITS-1:0];
    return sh[PW-1] ? SMIN : SMAX;
  endfunction

  function automatic logic signed [BITS-1:0] add_sat(input logic signed [BITS-1:0] a,
                                                     input logic signed [BITS-1:0] b);
    logic signed [BITS:0] s;
    s = (BITS+1)'(a) + (BITS+1)'(b);
    if (s[BITS] != s[BITS-1]) return s[BITS] ? SMIN : SMAX;
    return s[BITS-1:0];
  endfunction

  assign hid_ready = (state_q == RUN);
  assign hs        = hid_ready & hid_valid;
  assign w_rd_en   = hs;
  assign w_addr    = count_q;
  assign layer_2   = layer_2_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    h_d         = h_q;
    mac_d       = 1'b0;
    layer_2_d   = layer_2_q;
    out_valid_d = out_valid_q;
    // Weights for the previous handshake arrive this cycle.
    for (int k = 0; k < N_OUT; k++) begin
      acc_d[k] = acc_q[k];
      if (mac_q)
        acc_d[k] = add_sat(acc_q[k], mul_shift_sat(h_q, w_data[BITS*(N_OUT-k)-1 -: BITS]));
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < N_OUT; k++) acc_d[k] = bias[BITS*(N_OUT-k)-1 -: BITS];
          count_d = 8'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          h_d     = hid_data;
          mac_d   = 1'b1;
          count_d = count_q + 8'd1;
          if (count_q == 8'(HIDDEN - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Final accumulation lands here, so publish the updated values.
        for (int k = 0; k < N_OUT; k++) layer_2_d[BITS*(N_OUT-k)-1 -: BITS] = acc_d[k];
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ack) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 8'd0;
      h_q         <= '0;
      mac_q       <= 1'b0;
      layer_2_q   <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      h_q         <= h_d;
      mac_q       <= mac_d;
      layer_2_q   <= layer_2_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: doc/layer_2_mac.md
LAYER_2_MAC -- requirements
Module: layer_2_mac

Interface
REQ-001 SHALL have parameter BITS, default 32: signed fixed-point word width of activations, weights, biases and outputs.
REQ-002 SHALL have parameter FRAC, default 16: number of fractional bits in every word.
REQ-003 SHALL have parameter HIDDEN, default 16: number of hidden activations consumed per frame (2..255).
REQ-004 clk  in  1: single clock; every register updates on its rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 start  in  1: pulse that begins a frame; accepted only in IDLE.
REQ-007 hid_valid  in  1: hid_data is valid this cycle.
REQ-008 hid_data  in  BITS: signed hidden activation.
REQ-009 hid_ready  out  1: block accepts hid_data this cycle.
REQ-010 w_rd_en  out  1: weight-memory read strobe.
REQ-011 w_addr  out  8: hidden index being read.
REQ-012 w_data  in  BITS*10: the 10 weights for hidden index w_addr, returned exactly one cycle after w_rd_en; output k occupies bits [BITS*(10-k)-1 -: BITS].
REQ-013 bias  in  BITS*10: static per-output biases, with the same packing as w_data.
REQ-014 layer_2  out  BITS*10: registered output scores; score k occupies bits [BITS*(10-k)-1 -: BITS], with k=0 in the MSB slice and k=9 in the LSB slice.
REQ-015 out_valid  out  1: layer_2 holds a completed frame.
REQ-016 out_ack  in  1: consumer takes the frame.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN and OUT.
REQ-018 IDLE: when start=1, load acc[k]=bias[k] for all k, clear count, and go to RUN the next cycle.
REQ-019 RUN: hid_ready SHALL be 1.
- A handshake (hid_valid & hid_ready) drives w_rd_en=1 and w_addr=count in the same cycle, registers hid_data, and increments count.
- With no handshake, state and accumulators SHALL hold.
REQ-020 One cycle after each handshake, each acc[k] SHALL update to sat(acc[k] + sat(P_k)), where P_k = (h × w_k) >>> FRAC.
- h × w_k is the full 2*BITS signed product.
- >>> is an arithmetic shift, flooring toward negative infinity.
- sat clamps to the signed BITS range.
- The addition is evaluated in BITS+1 bits before saturation.
REQ-021 After the HIDDEN-th handshake, the block SHALL go to DRAIN with hid_ready=0; the final accumulation occurs in DRAIN.
REQ-022 DRAIN→OUT: layer_2 SHALL be loaded with acc[0..9] and out_valid=1 on entry to OUT.
REQ-023 OUT: out_valid and layer_2 SHALL hold stable until a cycle with out_ack=1, then out_valid=0 and go to IDLE the next cycle.
REQ-024 layer_2 SHALL retain the last frame after out_valid falls, until the next OUT entry.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 out_ack outside OUT SHALL be ignored.
REQ-027 Latency: with start at cycle 0 and hid_valid held high, out_valid=1 at cycle HIDDEN+2.
REQ-028 hid_valid stalls SHALL extend latency cycle-for-cycle without corrupting results.
REQ-029 w_rd_en SHALL be 0 in every cycle without a RUN handshake; w_addr is don't-care when w_rd_en=0.

Reset
REQ-030 On rst=1, the block SHALL asynchronously enter IDLE and clear count and acc[0..9].
REQ-031 On rst=1, outputs SHALL be hid_ready=0, w_rd_en=0, w_addr=0, out_valid=0 and layer_2=0.
REQ-032 Reset mid-frame SHALL abandon the frame; no partial result appears on layer_2.
REQ-033 The first start after rst deasserts SHALL behave as from power-up.

Verification
REQ-034 Bench HIDDEN=4, FRAC=16: all weights 1.0 (65536), bias 0, h=1.0,2.0,3.0,4.0 continuous → out_valid at cycle 6, every score = 655360.
REQ-035 Only output 7 weights = 2.0, others 0.5; bias[3]=-1.0; h all 1.0 → score7=524288, score3=65536, other scores=131072; the codebase argmax selects digit 7.
REQ-036 Weights 0x7FFFFFFF and h=0x7FFFFFFF for 4 cycles → every score saturates to 0x7FFFFFFF; negative mirror case gives 0x80000000.
REQ-037 Drive the REQ-034 stimulus with hid_valid low for 3 cycles between samples → identical scores; w_rd_en pulses exactly 4 times, with w_addr 0,1,2,3.
REQ-038 Hold out_ack=0 for 10 cycles in OUT with start pulsed meanwhile → layer_2 stable and the start is ignored; out_ack → IDLE; the next start runs normally.
REQ-039 Assert rst after 2 handshakes → out_valid=0 and layer_2=0 immediately; a fresh frame then yields correct scores.
